// File: rtl/zoom_view_if.sv
// zoom_view_if
//   Bundles the command handshake, frame strobe, pixel-coordinate input and
//   view/address outputs of the zoom view controller.
//   master : command/timing source (button/UART logic + VGA timing) and
//            framebuffer read side
//   slave  : zoom_view_ctrl
//   Signals:
//     cmd_valid/cmd/cmd_ready   view command handshake (cmd is 3 bits)
//     frame_start               one-cycle pulse at start of vertical blanking
//     pix_valid/pix_x/pix_y     VGA coordinate to map
//     zoom_shift/x_off/y_off    active view settings
//     sat                       pulse: last command clamped or had no effect
//     src_col/src_row/src_addr  mapped source location, qualified by addr_valid
interface zoom_view_if;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic        cmd_ready;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [1:0]  zoom_shift;
    logic [8:0]  x_off;
    logic [7:0]  y_off;
    logic        sat;
    logic [8:0]  src_col;
    logic [7:0]  src_row;
    logic [16:0] src_addr;
    logic        addr_valid;

    modport master (
        output cmd_valid, cmd, frame_start, pix_valid, pix_x, pix_y,
        input  cmd_ready, zoom_shift, x_off, y_off, sat,
               src_col, src_row, src_addr, addr_valid
    );

    modport slave (
        input  cmd_valid, cmd, frame_start, pix_valid, pix_x, pix_y,
        output cmd_ready, zoom_shift, x_off, y_off, sat,
               src_col, src_row, src_addr, addr_valid
    );
endinterface

// File: rtl/zoom_view_ctrl.sv
// zoom_view_ctrl
//   View controller for the pixel-replication zoom datapath. Takes view
//   commands, computes a clamped pending view, and commits it on the next
//   frame_start so a frame is never rendered with mixed settings. Also maps
//   each VGA coordinate to a source row/column/framebuffer address through a
//   2-stage pipeline that always uses the active view.
//   Ports:
//     clk    pixel/system clock
//     rst_n  asynchronous active-low reset
//     bus    zoom_view_if.slave (command handshake, frame strobe, pixel
//            coordinates in; view settings, sat, mapped address out)
module zoom_view_ctrl #(
    parameter int SRC_W     = 320,
    parameter int SRC_H     = 240,
    parameter int MAX_SHIFT = 2,
    parameter int PAN_STEP  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    zoom_view_if.slave  bus
);

    localparam int STAGES = 2;

    localparam logic [2:0] CMD_NOP        = 3'd0;
    localparam logic [2:0] CMD_ZOOM_IN    = 3'd1;
    localparam logic [2:0] CMD_ZOOM_OUT   = 3'd2;
    localparam logic [2:0] CMD_PAN_LEFT   = 3'd3;
    localparam logic [2:0] CMD_PAN_RIGHT  = 3'd4;
    localparam logic [2:0] CMD_PAN_UP     = 3'd5;
    localparam logic [2:0] CMD_PAN_DOWN   = 3'd6;
    localparam logic [2:0] CMD_RESET_VIEW = 3'd7;

    typedef enum logic [1:0] {IDLE, CALC, WAIT_FRAME} state_t;

    typedef struct packed {
        logic [1:0] shift;
        logic [8:0] x_off;
        logic [7:0] y_off;
    } view_t;

    // Largest legal offset for a given shift (source size minus window size).
    function automatic logic [8:0] x_span(input logic [1:0] s);
        return 9'(SRC_W - (SRC_W >> s));
    endfunction

    function automatic logic [7:0] y_span(input logic [1:0] s);
        return 8'(SRC_H - (SRC_H >> s));
    endfunction

    state_t      state_q, state_d;
    logic        accept;
    logic [2:0]  cmd_q;
    view_t       act_q, pend_q, calc_v;
    logic        sat_q, calc_sat;
    logic [1:0]  new_shift;
    logic [9:0]  x_sum;
    logic [8:0]  y_sum;

    // ---------------- command FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.cmd_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                // NOP is taken off the bus but never leaves IDLE.
                if (bus.cmd_valid && bus.cmd != CMD_NOP) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC:       state_d = WAIT_FRAME;
            WAIT_FRAME: if (bus.frame_start) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Pending view computed from the active view and the latched command.
    always_comb begin
        calc_v    = act_q;
        calc_sat  = 1'b0;
        new_shift = act_q.shift;
        x_sum     = {1'b0, act_q.x_off} + 10'(PAN_STEP);
        y_sum     = {1'b0, act_q.y_off} + 9'(PAN_STEP);
        case (cmd_q)
            CMD_ZOOM_IN, CMD_ZOOM_OUT: begin
                if (cmd_q == CMD_ZOOM_IN && act_q.shift < 2'(MAX_SHIFT))
                    new_shift = act_q.shift + 2'd1;
                else if (cmd_q == CMD_ZOOM_OUT && act_q.shift != 2'd0)
                    new_shift = act_q.shift - 2'd1;
                else
                    calc_sat = 1'b1;
                if (!calc_sat) begin
                    // Recentre the window on every zoom change.
                    calc_v.shift = new_shift;
                    calc_v.x_off = x_span(new_shift) >> 1;
                    calc_v.y_off = y_span(new_shift) >> 1;
                end
            end
            CMD_PAN_LEFT: begin
                if (act_q.x_off < 9'(PAN_STEP)) begin
                    calc_v.x_off = '0;
                    calc_sat     = 1'b1;
                end else begin
                    calc_v.x_off = act_q.x_off - 9'(PAN_STEP);
                end
            end
            CMD_PAN_RIGHT: begin
                if (x_sum > {1'b0, x_span(act_q.shift)}) begin
                    calc_v.x_off = x_span(act_q.shift);
                    calc_sat     = 1'b1;
                end else begin
                    calc_v.x_off = x_sum[8:0];
                end
            end
            CMD_PAN_UP: begin
                if (act_q.y_off < 8'(PAN_STEP)) begin
                    calc_v.y_off = '0;
                    calc_sat     = 1'b1;
                end else begin
                    calc_v.y_off = act_q.y_off - 8'(PAN_STEP);
                end
            end
            CMD_PAN_DOWN: begin
                if (y_sum > {1'b0, y_span(act_q.shift)}) begin
                    calc_v.y_off = y_span(act_q.shift);
                    calc_sat     = 1'b1;
                end else begin
                    calc_v.y_off = y_sum[7:0];
                end
            end
            CMD_RESET_VIEW: calc_v = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= CMD_NOP;
            pend_q <= '0;
            act_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (accept) cmd_q <= bus.cmd;
            if (state_q == CALC) pend_q <= calc_v;
            // sat is a single-cycle pulse on leaving CALC.
            sat_q <= (state_q == CALC) && calc_sat;
            // Commit only while waiting, so a frame_start seen in CALC is ignored.
            if (state_q == WAIT_FRAME && bus.frame_start) act_q <= pend_q;
        end
    end

    assign bus.zoom_shift = act_q.shift;
    assign bus.x_off      = act_q.x_off;
    assign bus.y_off      = act_q.y_off;
    assign bus.sat        = sat_q;

    // ---------------- address pipeline ----------------
    logic [STAGES-1:0] vld_pipe;
    logic [10:0]       col_sum;
    logic [9:0]        row_sum;
    logic [8:0]        col_c, s1_col, s2_col;
    logic [7:0]        row_c, s1_row, s2_row;
    logic [16:0]       s2_addr;

    always_comb begin
        col_sum = 11'(bus.pix_x >> act_q.shift) + 11'(act_q.x_off);
        row_sum = 10'(bus.pix_y >> act_q.shift) + 10'(act_q.y_off);
        col_c   = (col_sum > 11'(SRC_W - 1)) ? 9'(SRC_W - 1) : col_sum[8:0];
        row_c   = (row_sum > 10'(SRC_H - 1)) ? 8'(SRC_H - 1) : row_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
            s2_col   <= '0;
            s2_row   <= '0;
            s2_addr  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], bus.pix_valid};
            if (bus.pix_valid) begin
                s1_col <= col_c;
                s1_row <= row_c;
            end
            // Outputs only move on a valid beat; otherwise they hold.
            if (vld_pipe[0]) begin
                s2_col  <= s1_col;
                s2_row  <= s1_row;
                // row*320 as shift-add: 320 = 256 + 64.
                s2_addr <= (17'(s1_row) << 8) + (17'(s1_row) << 6) + 17'(s1_col);
            end
        end
    end

    assign bus.src_col    = s2_col;
    assign bus.src_row    = s2_row;
    assign bus.src_addr   = s2_addr;
    assign bus.addr_valid = vld_pipe[STAGES-1];

endmodule
